// File: rtl/uart_tx_frame_sequencer.sv
// Frame sequencer for a single uart_tx: sends SYNC, LEN, payload[0..LEN-1], then an
// additive checksum over LEN and payload, pacing each byte off uart_tx active/done.
module uart_tx_frame_sequencer #(
  parameter int          DEPTH     = 8,
  parameter int          ADDR_W    = 3,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Wr_En,
  input  logic [ADDR_W-1:0] i_Wr_Addr,
  input  logic [7:0]        i_Wr_Data,
  input  logic [ADDR_W:0]   i_Len,
  input  logic              i_Start,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Err,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_READY, S_ISSUE, S_WAIT, S_FINISH} state_t;
  typedef enum logic [1:0] {PH_SYNC, PH_LEN, PH_PAYLOAD, PH_CSUM} phase_t;

  state_t          state, state_next;
  phase_t          phase;
  logic [ADDR_W:0] len, idx;
  logic [7:0]      csum, tx_byte, cur_byte;
  logic [7:0]      mem [DEPTH];
  logic            done_q, err;
  logic            accept, reject, load_byte, issue, advance;
  logic            done_rise, len_ok;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign done_rise = i_Tx_Done & ~done_q;
  assign len_ok    = (i_Len != '0) && (i_Len <= DEPTH_L);

  assign o_Busy    = (state == S_READY) || (state == S_ISSUE) ||
                     (state == S_WAIT)  || (state == S_FINISH);
  assign o_Tx_DV   = (state == S_ISSUE);
  assign o_Done    = (state == S_FINISH);
  assign o_Err     = err;
  assign o_Tx_Byte = tx_byte;

  always_comb begin
    cur_byte = SYNC_BYTE;
    unique case (phase)
      PH_SYNC:    cur_byte = SYNC_BYTE;
      PH_LEN:     cur_byte = 8'(len);
      PH_PAYLOAD: cur_byte = mem[idx[ADDR_W-1:0]];
      PH_CSUM:    cur_byte = csum;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // READY waits for uart_tx to be fully idle (not in its done/cleanup cycle) before issuing
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    load_byte  = 1'b0;
    issue      = 1'b0;
    advance    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_Start) begin
          if (len_ok) begin
            accept     = 1'b1;
            state_next = S_READY;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_READY: begin
        if (!i_Tx_Active && !i_Tx_Done) begin
          load_byte  = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue      = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          advance    = 1'b1;
          state_next = (phase == PH_CSUM) ? S_FINISH : S_READY;
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      phase   <= PH_SYNC;
      len     <= '0;
      idx     <= '0;
      csum    <= '0;
      tx_byte <= '0;
      done_q  <= 1'b0;
      err     <= 1'b0;
    end else begin
      done_q <= i_Tx_Done;
      err    <= reject;
      if (accept) begin
        len   <= i_Len;
        csum  <= '0;
        phase <= PH_SYNC;
        idx   <= '0;
      end
      if (load_byte) tx_byte <= cur_byte;
      if (issue && (phase == PH_LEN || phase == PH_PAYLOAD))
        csum <= csum_add(csum, tx_byte);
      if (advance) begin
        unique case (phase)
          PH_SYNC: phase <= PH_LEN;
          PH_LEN: begin
            phase <= PH_PAYLOAD;
            idx   <= '0;
          end
          PH_PAYLOAD: begin
            // idx is one bit wider than the buffer address so len == DEPTH terminates cleanly
            if (idx + 1'b1 == len) phase <= PH_CSUM;
            else                   idx   <= idx + 1'b1;
          end
          PH_CSUM: phase <= PH_SYNC;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_Wr_En && !o_Busy) begin
      mem[i_Wr_Addr] <= i_Wr_Data;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_sequencer.sv
// Randomized bench for uart_tx_frame_sequencer with a simple uart_tx timing model
// and a frame-level reference model of the expected byte sequence.
module tb_uart_tx_frame_sequencer;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [ADDR_W:0]   len_in;
  logic              start;
  logic              busy, done, err, tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_active, tx_done;

  always #5 clk = ~clk;

  uart_tx_frame_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Wr_En(wr_en), .i_Wr_Addr(wr_addr), .i_Wr_Data(wr_data),
    .i_Len(len_in), .i_Start(start),
    .o_Busy(busy), .o_Done(done), .o_Err(err),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] model_mem [DEPTH];
  logic [7:0] cap [$];
  int         dv_cnt = 0, done_cnt = 0, err_cnt = 0;
  int         b_cycles = 4, d_hold = 1;
  int         rem_a = 0, rem_d = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // uart_tx model plus output monitor: active for b_cycles, then done held d_hold cycles
  initial begin
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (tx_dv) begin
        dv_cnt++;
        chk("dv_while_uart_busy", {30'd0, tx_active, tx_done}, 32'd0);
        cap.push_back(tx_byte);
      end
      if (rem_a > 0) begin
        rem_a--;
        if (rem_a == 0) begin
          tx_active = 1'b0;
          tx_done   = 1'b1;
          rem_d     = d_hold;
        end
      end else if (rem_d > 0) begin
        rem_d--;
        if (rem_d == 0) tx_done = 1'b0;
      end
      if (tx_dv) begin
        tx_active = 1'b1;
        rem_a     = b_cycles;
      end
    end
  end

  task automatic write_buf(input int addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = data;
    step();
    wr_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic check_frame(input int len, input string tag);
    logic [7:0] exp [$];
    logic [7:0] s;
    exp.push_back(8'hA5);
    exp.push_back(8'(len));
    s = 8'(len);
    for (int i = 0; i < len; i++) begin
      exp.push_back(model_mem[i]);
      s = s + model_mem[i];
    end
    exp.push_back(s);
    chk({tag, "_nbytes"}, cap.size(), exp.size());
    for (int i = 0; i < exp.size() && i < cap.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, cap[i]}, {24'd0, exp[i]});
  endtask

  task automatic run_frame(input int len, input string tag, input bit inject);
    int d0;
    bit busy_ok, got;
    cap.delete();
    d0     = done_cnt;
    len_in = (ADDR_W+1)'(len);
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    busy_ok = 1'b1;
    got     = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      if (inject && i == 4) begin
        wr_en = 1'b1; wr_addr = '0; wr_data = 8'h55;
        start = 1'b1; len_in = 4'd2;
      end
      if (inject && i == 5) begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      step();
      if (done_cnt > d0) got = 1'b1;
      else if (!busy)    busy_ok = 1'b0;
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_busy_held"}, busy_ok, 1);
    step();
    chk({tag, "_busy_cleared"}, busy, 0);
    repeat (inject ? 60 : 4) step();
    chk({tag, "_done_once"}, done_cnt - d0, 1);
    check_frame(len, tag);
  endtask

  task automatic try_bad(input int len, input string tag);
    int e0, v0;
    e0     = err_cnt;
    v0     = dv_cnt;
    len_in = (ADDR_W+1)'(len);
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk({tag, "_err_pulse"}, err, 1);
    chk({tag, "_busy_low"}, busy, 0);
    repeat (5) step();
    chk({tag, "_err_once"}, err_cnt - e0, 1);
    chk({tag, "_no_dv"}, dv_cnt - v0, 0);
    chk({tag, "_still_idle"}, busy, 0);
  endtask

  initial begin
    int len, d0;
    bit reached;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len_in = '0; start = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    repeat (3) step();
    chk("reset_outputs", {20'd0, busy, done, err, tx_dv, tx_byte}, 32'd0);
    rst_n = 1'b1;
    step();

    write_buf(0, 8'h01); write_buf(1, 8'h02); write_buf(2, 8'h03);
    b_cycles = 5; d_hold = 1;
    run_frame(3, "basic", 1'b0);
    run_frame(3, "busy_ignore", 1'b1);
    run_frame(3, "buf_kept", 1'b0);

    write_buf(0, 8'hFF); write_buf(1, 8'hFF);
    run_frame(2, "csum_wrap", 1'b0);

    try_bad(0, "len0");
    try_bad(9, "len9");
    try_bad(15, "len15");

    d_hold = 2; b_cycles = 3;
    run_frame(3, "done2", 1'b0);

    for (int k = 0; k < 10; k++) begin
      for (int a = 0; a < DEPTH; a++) write_buf(a, 8'($urandom));
      b_cycles = $urandom_range(1, 10);
      d_hold   = $urandom_range(1, 3);
      len      = (k == 0) ? DEPTH : $urandom_range(1, DEPTH);
      run_frame(len, $sformatf("rnd%0d", k), 1'b0);
      if (k % 3 == 0) try_bad($urandom_range(9, 15), $sformatf("rndbad%0d", k));
    end

    for (int a = 0; a < DEPTH; a++) write_buf(a, 8'($urandom_range(1, 255)));
    b_cycles = 6; d_hold = 1;
    cap.delete();
    d0     = done_cnt;
    len_in = 4'd8;
    start  = 1'b1;
    step();
    start   = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      step();
      if (cap.size() >= 4) reached = 1'b1;
    end
    chk("rst_mid_reached_payload", reached, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {20'd0, busy, done, err, tx_dv, tx_byte}, 32'd0);
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (30) step();
    chk("rst_mid_no_done", done_cnt - d0, 0);
    run_frame(1, "after_rst", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_sequencer.md
Name: uart_tx_frame_sequencer

Overview:
Sequences one uart_tx instance to send a framed packet from a small local byte buffer: SYNC byte, LEN byte, LEN payload bytes, then an 8-bit additive checksum. Upstream logic, such as the sort FSM, loads the buffer and pulses start. The sequencer drives uart_tx's data-valid/byte inputs and paces itself off uart_tx's active/done outputs. It sits between the sort datapath and the UART transmitter.

Parameters:
DEPTH, 8, payload buffer depth in bytes (power of two, 2..256)
ADDR_W, 3, buffer address width (log2 DEPTH)
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
i_Clock  in  1  system clock
i_Rst_n  in  1  asynchronous active-low reset
i_Wr_En  in  1  buffer write strobe
i_Wr_Addr  in  ADDR_W  buffer write address
i_Wr_Data  in  8  buffer write data
i_Len  in  ADDR_W+1  payload length, sampled on i_Start
i_Start  in  1  start-frame request (level sampled per cycle)
o_Busy  out  1  high from accepted start until frame complete
o_Done  out  1  one-cycle pulse after checksum byte completes
o_Err  out  1  one-cycle pulse when a start is rejected for bad length
o_Tx_DV  out  1  to uart_tx data-valid, one-cycle pulse per byte
o_Tx_Byte  out  8  to uart_tx byte; held stable from DV until next issue
i_Tx_Active  in  1  from uart_tx active
i_Tx_Done  in  1  from uart_tx done (may stay high more than one cycle)

Behaviour:
- Reset (async assert, sync release): all outputs 0, state S_IDLE, buffer cleared to 0, counters and checksum 0.
- Buffer writes: accepted only when o_Busy=0. Writes while busy are ignored.
- Start acceptance, S_IDLE with i_Start=1:
  - i_Len=0 or i_Len>DEPTH: pulse o_Err, stay S_IDLE, o_Busy stays 0.
  - Otherwise: latch len, clear checksum, set phase=SYNC, o_Busy=1 next cycle, go S_READY.
  - i_Start while busy is ignored.
- Phases, in order: SYNC (SYNC_BYTE), LEN (latched len, low 8 bits), PAYLOAD (buf[0..len-1]), CSUM.
- Checksum: 8-bit sum mod 256 of the LEN byte and all payload bytes. SYNC is excluded. Added when each byte is issued.
- S_READY: wait until i_Tx_Active=0 and i_Tx_Done=0. This guarantees uart_tx is back in idle and not in its cleanup cycle. Then go S_ISSUE.
- S_ISSUE (one cycle):
  - o_Tx_DV=1, o_Tx_Byte=current phase byte, update checksum.
  - Go S_WAIT.
- S_WAIT: wait for rising edge of i_Tx_Done (registered previous value 0, current 1). Then advance phase/index:
  - More bytes remain: go S_READY.
  - CSUM byte just completed: go S_FINISH.
- S_FINISH (one cycle): o_Done=1, o_Busy=0 next cycle, go S_IDLE.
- Per-byte latency: DV issued no earlier than 1 cycle after uart_tx is idle with done low.
- Index wrap: payload index is ADDR_W+1 bits. len=DEPTH reads buf[0..DEPTH-1], never wrapping past the buffer.
- Illegal state encoding: go S_IDLE, o_Busy=0.
- Reset mid-frame: frame abandoned immediately; no o_Done; o_Tx_DV forced 0. uart_tx finishes any in-flight byte on its own.

Test Plan:
1. Load buf = 01,02,03; i_Len=3; pulse i_Start. Require uart_tx to receive exactly 6 DV pulses with bytes A5,03,01,02,03,09. o_Done pulses once after the 6th done edge. o_Busy is high throughout.
2. Payload FF,FF; i_Len=2. Require checksum wraparound: frame A5,02,FF,FF,00.
3. i_Len=0, then i_Len=9 with DEPTH=8. Require an o_Err pulse each time, no o_Tx_DV, o_Busy stays 0.
4. During frame 1, write buf[0]=55 and pulse i_Start again. Require the frame bytes to be unchanged and no second frame. After o_Done, the buffer still reads 01.
5. Model uart_tx with done held high 2 cycles. Require exactly one phase advance per byte, and no DV while i_Tx_Done=1 or i_Tx_Active=1.
6. Assert i_Rst_n=0 during the payload phase. Require all outputs 0 asynchronously. After release, a new start with len=1 and buf[0]=00 (cleared) sends A5,01,00,01.
